// File: rtl/ctrl_logic_fsm.sv
// Byte command processor between the UART RX and TX FIFOs.
// Supports ping, write, read and clear commands on a small register store.
module ctrl_logic_fsm #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] rx_data,
    input  logic                  rx_valid,
    output logic                  rx_ready,
    output logic [DATA_WIDTH-1:0] tx_data,
    output logic                  tx_valid,
    input  logic                  tx_ready
);
    localparam int AW = $clog2(DEPTH);

    localparam logic [DATA_WIDTH-1:0] CMD_PING  = DATA_WIDTH'(8'h61);
    localparam logic [DATA_WIDTH-1:0] CMD_WRITE = DATA_WIDTH'(8'h77);
    localparam logic [DATA_WIDTH-1:0] CMD_READ  = DATA_WIDTH'(8'h72);
    localparam logic [DATA_WIDTH-1:0] CMD_CLEAR = DATA_WIDTH'(8'h63);
    localparam logic [DATA_WIDTH-1:0] RSP_O     = DATA_WIDTH'(8'h6F);
    localparam logic [DATA_WIDTH-1:0] RSP_K     = DATA_WIDTH'(8'h6B);
    localparam logic [DATA_WIDTH-1:0] RSP_UNK   = DATA_WIDTH'(8'h3F);

    typedef enum logic [2:0] {
        S_IDLE,
        S_GET_ADDR,
        S_GET_DATA,
        S_SEND0,
        S_SEND1
    } state_t;

    state_t                r_state;
    state_t                w_next_state;
    logic                  r_rx_ready;
    logic                  r_tx_valid;
    logic [DATA_WIDTH-1:0] r_tx_data;
    logic                  r_is_write;
    logic                  r_second;
    logic [AW-1:0]         r_addr;
    logic [DATA_WIDTH-1:0] r_store [DEPTH];

    logic                  w_rx_beat;
    logic                  w_tx_beat;
    logic                  w_load;
    logic [DATA_WIDTH-1:0] w_load_data;
    logic                  w_set_write;
    logic                  w_set_read;
    logic                  w_second_set;
    logic                  w_second_clr;
    logic                  w_wr_en;
    logic                  w_clr;
    logic                  w_cap_addr;

    assign w_rx_beat = rx_valid & r_rx_ready;
    assign w_tx_beat = r_tx_valid & tx_ready;

    always_comb begin
        w_next_state = r_state;
        w_load       = 1'b0;
        w_load_data  = '0;
        w_set_write  = 1'b0;
        w_set_read   = 1'b0;
        w_second_set = 1'b0;
        w_second_clr = 1'b0;
        w_wr_en      = 1'b0;
        w_clr        = 1'b0;
        w_cap_addr   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_rx_beat) begin
                    w_next_state = S_SEND0;
                    w_load       = 1'b1;
                    if (rx_data == CMD_WRITE) begin
                        w_next_state = S_GET_ADDR;
                        w_load       = 1'b0;
                        w_set_write  = 1'b1;
                    end else if (rx_data == CMD_READ) begin
                        w_next_state = S_GET_ADDR;
                        w_load       = 1'b0;
                        w_set_read   = 1'b1;
                    end else if (rx_data == CMD_PING) begin
                        w_load_data  = RSP_O;
                        w_second_set = 1'b1;
                    end else if (rx_data == CMD_CLEAR) begin
                        w_load_data  = RSP_K;
                        w_clr        = 1'b1;
                    end else begin
                        w_load_data  = RSP_UNK;
                    end
                end
            end
            S_GET_ADDR: begin
                if (w_rx_beat) begin
                    if (r_is_write) begin
                        w_next_state = S_GET_DATA;
                        w_cap_addr   = 1'b1;
                    end else begin
                        w_next_state = S_SEND0;
                        w_load       = 1'b1;
                        w_load_data  = r_store[rx_data[AW-1:0]];
                    end
                end
            end
            S_GET_DATA: begin
                if (w_rx_beat) begin
                    w_next_state = S_SEND0;
                    w_wr_en      = 1'b1;
                    w_load       = 1'b1;
                    w_load_data  = RSP_K;
                end
            end
            S_SEND0: begin
                if (w_tx_beat) begin
                    if (r_second) begin
                        // Second ping byte is loaded on the same beat so tx_valid never drops
                        w_next_state = S_SEND1;
                        w_load       = 1'b1;
                        w_load_data  = RSP_K;
                        w_second_clr = 1'b1;
                    end else begin
                        w_next_state = S_IDLE;
                    end
                end
            end
            S_SEND1: begin
                if (w_tx_beat) begin
                    w_next_state = S_IDLE;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rx_ready <= 1'b0;
            r_tx_valid <= 1'b0;
            r_tx_data  <= '0;
            r_is_write <= 1'b0;
            r_second   <= 1'b0;
            r_addr     <= '0;
        end else begin
            r_rx_ready <= (w_next_state == S_IDLE) || (w_next_state == S_GET_ADDR) ||
                          (w_next_state == S_GET_DATA);
            if (w_load) begin
                r_tx_valid <= 1'b1;
                r_tx_data  <= w_load_data;
            end else if (w_tx_beat) begin
                r_tx_valid <= 1'b0;
            end
            if (w_set_write) r_is_write <= 1'b1;
            else if (w_set_read) r_is_write <= 1'b0;
            if (w_second_set) r_second <= 1'b1;
            else if (w_second_clr) r_second <= 1'b0;
            if (w_cap_addr) r_addr <= rx_data[AW-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) r_store[i] <= '0;
        end else if (w_clr) begin
            for (int i = 0; i < DEPTH; i++) r_store[i] <= '0;
        end else if (w_wr_en) begin
            r_store[r_addr] <= rx_data;
        end
    end

    assign rx_ready = r_rx_ready;
    assign tx_valid = r_tx_valid;
    assign tx_data  = r_tx_data;
endmodule

// File: tb/tb_ctrl_logic_fsm.sv
// Directed bench for ctrl_logic_fsm: ping, write/read, wrap, back-pressure, clear, reset.
module tb_ctrl_logic_fsm;
    logic       clk;
    logic       rst_n;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;

    int n_checks = 0;
    int n_errors = 0;

    ctrl_logic_fsm #(.DATA_WIDTH(8), .DEPTH(16)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_ready (rx_ready),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Called at a falling edge; returns at the falling edge after the RX beat.
    task automatic rx_byte(input logic [7:0] b);
        int n;
        n = 0;
        rx_data  = b;
        rx_valid = 1'b1;
        while (!rx_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!rx_ready) chk("rx_timeout", 32'd0, 32'd1);
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic tx_byte(input string tag, input logic [7:0] exp);
        int n;
        n = 0;
        tx_ready = 1'b1;
        while (!tx_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_valid"}, {31'd0, tx_valid}, 32'd1);
        chk(tag, {24'd0, tx_data}, {24'd0, exp});
        @(negedge clk);
        tx_ready = 1'b0;
    endtask

    initial begin
        logic [7:0] got [$];
        bit         stable;

        rst_n    = 1'b0;
        rx_data  = 8'h00;
        rx_valid = 1'b0;
        tx_ready = 1'b0;

        // Reset
        #100;
        @(negedge clk);
        chk("rst_rx_ready", {31'd0, rx_ready}, 32'd0);
        chk("rst_tx_valid", {31'd0, tx_valid}, 32'd0);
        chk("rst_tx_data", {24'd0, tx_data}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rel_rx_ready", {31'd0, rx_ready}, 32'd1);

        // Ping with tx_ready held high: two consecutive beats
        rx_byte(8'h61);
        chk("ping_v0", {31'd0, tx_valid}, 32'd1);
        chk("ping_d0", {24'd0, tx_data}, 32'h6F);
        chk("ping_rxr0", {31'd0, rx_ready}, 32'd0);
        tx_ready = 1'b1;
        @(negedge clk);
        chk("ping_v1", {31'd0, tx_valid}, 32'd1);
        chk("ping_d1", {24'd0, tx_data}, 32'h6B);
        @(negedge clk);
        chk("ping_v2", {31'd0, tx_valid}, 32'd0);
        chk("ping_idle_rxr", {31'd0, rx_ready}, 32'd1);
        tx_ready = 1'b0;

        // Write then read, including address wrap
        rx_byte(8'h77); rx_byte(8'h05); rx_byte(8'hA5);
        tx_byte("wr_ack", 8'h6B);
        rx_byte(8'h72); rx_byte(8'h05);
        tx_byte("rd_05", 8'hA5);
        rx_byte(8'h72); rx_byte(8'h15);
        tx_byte("rd_15_wrap", 8'hA5);
        rx_byte(8'h72); rx_byte(8'h06);
        tx_byte("rd_06", 8'h00);

        // Back-pressure on ping
        rx_byte(8'h61);
        stable = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (!tx_valid || tx_data != 8'h6F || rx_ready) stable = 1'b0;
            @(negedge clk);
        end
        chk("bp_stable", {31'd0, stable}, 32'd1);
        chk("bp_data", {24'd0, tx_data}, 32'h6F);
        tx_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (tx_valid) got.push_back(tx_data);
            @(negedge clk);
        end
        tx_ready = 1'b0;
        chk("bp_count", got.size(), 32'd2);
        if (got.size() == 2) begin
            chk("bp_b0", {24'd0, got[0]}, 32'h6F);
            chk("bp_b1", {24'd0, got[1]}, 32'h6B);
        end

        // Clear and unknown command
        rx_byte(8'h77); rx_byte(8'h02); rx_byte(8'h3C);
        tx_byte("wr2_ack", 8'h6B);
        rx_byte(8'h72); rx_byte(8'h02);
        tx_byte("rd2_pre", 8'h3C);
        rx_byte(8'h63);
        tx_byte("clr_ack", 8'h6B);
        rx_byte(8'h72); rx_byte(8'h02);
        tx_byte("rd2_post", 8'h00);
        rx_byte(8'h72); rx_byte(8'h05);
        tx_byte("rd5_post", 8'h00);
        rx_byte(8'h5A);
        tx_byte("unk", 8'h3F);

        // Reset mid-command
        rx_byte(8'h77); rx_byte(8'h05); rx_byte(8'h77);
        tx_byte("wr5_ack", 8'h77 ^ 8'h1C);
        rx_byte(8'h77); rx_byte(8'h01);
        rst_n = 1'b0;
        @(negedge clk);
        chk("mid_rst_rxr", {31'd0, rx_ready}, 32'd0);
        chk("mid_rst_txv", {31'd0, tx_valid}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("mid_rel_rxr", {31'd0, rx_ready}, 32'd1);
        chk("mid_rel_txv", {31'd0, tx_valid}, 32'd0);
        rx_byte(8'h72); rx_byte(8'h01);
        tx_byte("rd1_after_rst", 8'h00);
        rx_byte(8'h72); rx_byte(8'h05);
        tx_byte("rd5_after_rst", 8'h00);
        tx_ready = 1'b1;
        stable = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (tx_valid) stable = 1'b0;
            @(negedge clk);
        end
        tx_ready = 1'b0;
        chk("no_stray_tx", {31'd0, stable}, 32'd1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end
endmodule
